// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the rv32i core.
// Owns the PC and issues one-cycle request pulses to icache, decoder, ALU and dcache. It also
// provides a per-state watchdog, illegal/misaligned traps, a halt at instruction boundaries
// and a retired-instruction counter.
module mc_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT     = 64,
    parameter bit              CHECK_ALIGN = 1'b1,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    output logic             ic_req_valid,
    output logic [XLEN-1:0]  ic_pc,
    input  logic             ic_resp_valid,
    output logic             dec_req_valid,
    input  logic             dec_resp_valid,
    input  logic             dec_illegal,
    input  logic             dec_is_jump,
    input  logic             dec_is_branch,
    input  logic             dec_is_mem,
    input  logic             dec_writes_rd,
    output logic             alu_req_valid,
    input  logic             alu_resp_valid,
    input  logic             alu_taken,
    input  logic [XLEN-1:0]  alu_target,
    output logic             dc_req_valid,
    input  logic             dc_resp_valid,
    output logic             rf_write_en,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5,
        S_HALTED    = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

    // Watchdog counter sized to hold TIMEOUT; one bit minimum keeps the disabled case legal.
    localparam int              WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          st;
    state_t          st_nxt;
    logic            entry;
    logic [XLEN-1:0] pc;
    logic [WD_W-1:0] wd_cnt;
    logic            redir_q;
    logic [XLEN-1:0] tgt_q;

    logic            resp_hit;
    logic            waiting;
    logic            wd_expire;
    logic            redir_now;
    logic [XLEN-1:0] tgt_now;
    logic            misalign;
    logic            retire_redir;
    logic [XLEN-1:0] retire_tgt;
    logic            do_retire;
    logic            trap_go;
    logic [1:0]      cause_nxt;

    // Jump/branch decision and halfword-aligned target, live while the ALU responds.
    assign redir_now = dec_is_jump | (dec_is_branch & alu_taken);
    assign tgt_now   = alu_target & ~XLEN'(1);
    assign misalign  = redir_now & CHECK_ALIGN & tgt_now[1];

    // Retiring straight out of EXECUTE uses the live decision; later states use the registered copy.
    assign retire_redir = (st == S_EXECUTE) ? redir_now : redir_q;
    assign retire_tgt   = (st == S_EXECUTE) ? tgt_now   : tgt_q;

    assign waiting   = st inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY};
    assign wd_expire = (TIMEOUT > 0) && waiting && !resp_hit && (wd_cnt == WD_LAST);

    // Select the response belonging to the current state; responses for other units are ignored.
    always_comb begin
        resp_hit = 1'b0;
        case (st)
            S_FETCH:   resp_hit = ic_resp_valid;
            S_DECODE:  resp_hit = dec_resp_valid;
            S_EXECUTE: resp_hit = alu_resp_valid;
            S_MEMORY:  resp_hit = dc_resp_valid;
            default:   resp_hit = 1'b0;
        endcase
    end

    // Next-state decision: unit responses, traps, retire and halt.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        st_nxt    = st;
        do_retire = 1'b0;
        trap_go   = 1'b0;
        cause_nxt = 2'd0;
        case (st)
            S_FETCH: begin
                if (ic_resp_valid) st_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (dec_resp_valid) begin
                    if (dec_illegal) begin
                        trap_go   = 1'b1;
                        cause_nxt = CAUSE_ILLEGAL;
                    end else begin
                        st_nxt = S_EXECUTE;
                    end
                end
            end
            S_EXECUTE: begin
                if (alu_resp_valid) begin
                    if (misalign) begin
                        trap_go   = 1'b1;
                        cause_nxt = CAUSE_MISALIGNED;
                    end else if (dec_is_mem) begin
                        st_nxt = S_MEMORY;
                    end else if (dec_writes_rd) begin
                        st_nxt = S_WRITEBACK;
                    end else begin
                        do_retire = 1'b1;
                    end
                end
            end
            S_MEMORY: begin
                if (dc_resp_valid) begin
                    if (dec_writes_rd) st_nxt = S_WRITEBACK;
                    else               do_retire = 1'b1;
                end
            end
            S_WRITEBACK: do_retire = 1'b1;
            S_HALTED: begin
                if (!halt) st_nxt = S_FETCH;
            end
            default: st_nxt = st;
        endcase
        if (wd_expire) begin
            trap_go   = 1'b1;
            cause_nxt = CAUSE_TIMEOUT;
        end
        if (do_retire) st_nxt = halt ? S_HALTED : S_FETCH;
        if (trap_go)   st_nxt = S_TRAP;
    end

    // Sequencer state, PC, watchdog, trap record and retire counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            st         <= S_FETCH;
            entry      <= 1'b1;
            pc         <= RESET_PC;
            wd_cnt     <= '0;
            redir_q    <= 1'b0;
            tgt_q      <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            trap_pc    <= '0;
            instret    <= '0;
        end else begin
            st    <= st_nxt;
            entry <= (st_nxt != st);

            if (st_nxt != st)
                wd_cnt <= '0;
            else if (waiting && !resp_hit && (TIMEOUT > 0))
                wd_cnt <= wd_cnt + 1'b1;

            if (st == S_EXECUTE && alu_resp_valid) begin
                redir_q <= redir_now;
                tgt_q   <= tgt_now;
            end

            if (do_retire) begin
                pc      <= retire_redir ? retire_tgt : pc + XLEN'(4);
                instret <= instret + 1'b1;
            end

            if (trap_go) begin
                trap       <= 1'b1;
                trap_cause <= cause_nxt;
                trap_pc    <= pc;
            end
        end
    end

    // Each request is high only in the first cycle of its state and never during reset.
    assign ic_req_valid  = ~rst & entry & (st == S_FETCH);
    assign dec_req_valid = ~rst & entry & (st == S_DECODE);
    assign alu_req_valid = ~rst & entry & (st == S_EXECUTE);
    assign dc_req_valid  = ~rst & entry & (st == S_MEMORY);
    assign rf_write_en   = ~rst & (st == S_WRITEBACK);
    assign ic_pc         = pc;
    assign state         = st;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed bench for mc_sequencer (TIMEOUT=8). Each step drives one cycle of
// responses and pushes the expected state/request pattern for that cycle; a monitor pops and
// compares it shortly after the falling edge.
module tb_mc_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    // Control vector: {rst, halt, ic_resp, dec_resp, alu_resp, dc_resp}
    localparam logic [5:0] C_0    = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b100000;
    localparam logic [5:0] C_HALT = 6'b010000;
    localparam logic [5:0] C_IC   = 6'b001000;
    localparam logic [5:0] C_DEC  = 6'b000100;
    localparam logic [5:0] C_ALU  = 6'b000010;
    localparam logic [5:0] C_DC   = 6'b000001;

    // Request vector: {ic, dec, alu, dc, rf_write_en}
    localparam logic [4:0] Q_0   = 5'b00000;
    localparam logic [4:0] Q_IC  = 5'b10000;
    localparam logic [4:0] Q_DEC = 5'b01000;
    localparam logic [4:0] Q_ALU = 5'b00100;
    localparam logic [4:0] Q_DC  = 5'b00010;
    localparam logic [4:0] Q_RF  = 5'b00001;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5, H = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] req;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             halt;
    logic             ic_req_valid;
    logic [XLEN-1:0]  ic_pc;
    logic             ic_resp_valid;
    logic             dec_req_valid;
    logic             dec_resp_valid;
    logic             dec_illegal;
    logic             dec_is_jump;
    logic             dec_is_branch;
    logic             dec_is_mem;
    logic             dec_writes_rd;
    logic             alu_req_valid;
    logic             alu_resp_valid;
    logic             alu_taken;
    logic [XLEN-1:0]  alu_target;
    logic             dc_req_valid;
    logic             dc_resp_valid;
    logic             rf_write_en;
    logic [2:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [XLEN-1:0]  trap_pc;
    logic [CNT_W-1:0] instret;

    exp_t            sb[$];
    int              n_total = 0;
    int              n_pass  = 0;
    logic [XLEN-1:0] exp_pc;
    logic [CNT_W-1:0] exp_ir;

    mc_sequencer #(
        .XLEN(XLEN), .RESET_PC('0), .TIMEOUT(8), .CHECK_ALIGN(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .ic_req_valid(ic_req_valid), .ic_pc(ic_pc), .ic_resp_valid(ic_resp_valid),
        .dec_req_valid(dec_req_valid), .dec_resp_valid(dec_resp_valid),
        .dec_illegal(dec_illegal), .dec_is_jump(dec_is_jump), .dec_is_branch(dec_is_branch),
        .dec_is_mem(dec_is_mem), .dec_writes_rd(dec_writes_rd),
        .alu_req_valid(alu_req_valid), .alu_resp_valid(alu_resp_valid),
        .alu_taken(alu_taken), .alu_target(alu_target),
        .dc_req_valid(dc_req_valid), .dc_resp_valid(dc_resp_valid),
        .rf_write_en(rf_write_en), .state(state), .trap(trap), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One cycle: drive responses for this cycle and queue what the DUT should show in it.
    task automatic step(input logic [5:0] ctl, input logic [2:0] est, input logic [4:0] ereq);
        exp_t e;
        @(negedge clk);
        {rst, halt, ic_resp_valid, dec_resp_valid, alu_resp_valid, dc_resp_valid} = ctl;
        e.st  = est;
        e.req = ereq;
        sb.push_back(e);
    endtask

    task automatic set_cls(input logic ill, input logic jmp, input logic br, input logic mem,
                           input logic rd, input logic tkn, input logic [XLEN-1:0] tgt);
        dec_illegal   = ill;
        dec_is_jump   = jmp;
        dec_is_branch = br;
        dec_is_mem    = mem;
        dec_writes_rd = rd;
        alu_taken     = tkn;
        alu_target    = tgt;
    endtask

    // From the fetch request cycle (already stepped): fetch response, decode request, decode response.
    task automatic fd();
        step(C_IC, F, Q_0);
        step(C_0, D, Q_DEC);
        step(C_DEC, D, Q_0);
    endtask

    task automatic ex();
        step(C_0, E, Q_ALU);
        step(C_ALU, E, Q_0);
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"}, 64'(ic_pc), 64'(exp_pc));
        check({tag, "_instret"}, 64'(instret), 64'(exp_ir));
    endtask

    // Scoreboard monitor: compare each queued cycle expectation just after the falling edge.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", 64'(state), 64'(e.st));
            check("req", 64'({ic_req_valid, dec_req_valid, alu_req_valid, dc_req_valid, rf_write_en}),
                  64'(e.req));
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; halt = 1'b0;
        ic_resp_valid = 1'b0; dec_resp_valid = 1'b0; alu_resp_valid = 1'b0; dc_resp_valid = 1'b0;
        set_cls(0, 0, 0, 0, 0, 0, '0);
        exp_pc = '0;
        exp_ir = '0;

        // Reset: requests masked while rst is high, all records cleared.
        step(C_RST, F, Q_0);
        step(C_RST, F, Q_0);
        check_arch("reset");
        check("reset_trap", 64'(trap), 64'd0);
        check("reset_cause", 64'(trap_cause), 64'd0);
        check("reset_trap_pc", 64'(trap_pc), 64'd0);
        step(C_0, F, Q_IC);

        // ADDI: F,D,E,W then back to FETCH at pc+4.
        set_cls(0, 0, 0, 0, 1, 0, '0);
        fd(); ex();
        step(C_0, W, Q_RF);
        step(C_0, F, Q_IC);
        exp_pc = 32'h4; exp_ir = 1;
        check_arch("addi");

        // JAL to 0x101: target bit 0 dropped, retire through WRITEBACK to 0x100.
        set_cls(0, 1, 0, 0, 1, 0, 32'h101);
        fd(); ex();
        step(C_0, W, Q_RF);
        step(C_0, F, Q_IC);
        exp_pc = 32'h100; exp_ir = 2;
        check_arch("jal");

        // Branch not taken (misaligned target must not matter), retire from EXECUTE.
        set_cls(0, 0, 1, 0, 0, 0, 32'h202);
        fd(); ex();
        step(C_0, F, Q_IC);
        exp_pc = 32'h104; exp_ir = 3;
        check_arch("br_nt");

        // Branch taken, retire from EXECUTE with redirect.
        set_cls(0, 0, 1, 0, 0, 1, 32'h201);
        fd(); ex();
        step(C_0, F, Q_IC);
        exp_pc = 32'h200; exp_ir = 4;
        check_arch("br_t");

        // LW: F,D,E,M,W with one dc request pulse.
        set_cls(0, 0, 0, 1, 1, 0, '0);
        fd(); ex();
        step(C_0, M, Q_DC);
        step(C_DC, M, Q_0);
        step(C_0, W, Q_RF);
        step(C_0, F, Q_IC);
        exp_pc = 32'h204; exp_ir = 5;
        check_arch("lw");

        // Halt raised in EXECUTE: instruction completes, then HALTED ignoring stray responses.
        set_cls(0, 0, 0, 0, 1, 0, '0);
        fd();
        step(C_HALT, E, Q_ALU);
        step(C_HALT | C_ALU, E, Q_0);
        step(C_HALT, W, Q_RF);
        step(C_HALT, H, Q_0);
        step(C_HALT | C_IC, H, Q_0);
        exp_pc = 32'h208; exp_ir = 6;
        check_arch("halted");
        step(C_0, H, Q_0);
        step(C_0, F, Q_IC);
        check_arch("resume");

        // LW with dc response on the 8th waiting cycle: response wins over expiry.
        set_cls(0, 0, 0, 1, 1, 0, '0);
        fd(); ex();
        step(C_0, M, Q_DC);
        repeat (6) step(C_0, M, Q_0);
        step(C_DC, M, Q_0);
        step(C_0, W, Q_RF);
        step(C_0, F, Q_IC);
        exp_pc = 32'h20C; exp_ir = 7;
        check_arch("wd_edge");
        check("wd_edge_trap", 64'(trap), 64'd0);

        // JAL to 0x102: misaligned trap, no requests in TRAP even with responses present.
        set_cls(0, 1, 0, 0, 1, 0, 32'h102);
        fd(); ex();
        step(C_IC | C_DEC | C_ALU | C_DC, T, Q_0);
        step(C_0, T, Q_0);
        check("mis_trap", 64'(trap), 64'd1);
        check("mis_cause", 64'(trap_cause), 64'd2);
        check("mis_trap_pc", 64'(trap_pc), 64'h20C);
        check_arch("mis");
        step(C_RST, T, Q_0);
        step(C_0, F, Q_IC);
        exp_pc = '0; exp_ir = 0;
        check_arch("rst2");
        check("rst2_trap", 64'(trap), 64'd0);

        // LW with dc response withheld: timeout trap on the 8th waiting cycle.
        set_cls(0, 0, 0, 1, 1, 0, '0);
        fd(); ex();
        step(C_0, M, Q_DC);
        repeat (7) step(C_0, M, Q_0);
        step(C_0, T, Q_0);
        check("to_trap", 64'(trap), 64'd1);
        check("to_cause", 64'(trap_cause), 64'd3);
        check("to_trap_pc", 64'(trap_pc), 64'h0);
        step(C_RST, T, Q_0);
        step(C_0, F, Q_IC);

        // Illegal instruction: trap straight out of DECODE.
        set_cls(1, 0, 0, 0, 1, 0, '0);
        step(C_IC, F, Q_0);
        step(C_0, D, Q_DEC);
        step(C_DEC, D, Q_0);
        step(C_0, T, Q_0);
        check("ill_cause", 64'(trap_cause), 64'd1);
        check("ill_trap", 64'(trap), 64'd1);
        step(C_RST, T, Q_0);
        step(C_0, F, Q_IC);

        // ADDI, then reset during MEMORY of a LW with dc response high.
        set_cls(0, 0, 0, 0, 1, 0, '0);
        fd(); ex();
        step(C_0, W, Q_RF);
        step(C_0, F, Q_IC);
        exp_pc = 32'h4; exp_ir = 1;
        check_arch("pre_rst");
        set_cls(0, 0, 0, 1, 1, 0, '0);
        fd(); ex();
        step(C_0, M, Q_DC);
        step(C_RST | C_DC, M, Q_0);
        step(C_0, F, Q_IC);
        exp_pc = '0; exp_ir = 0;
        check_arch("mid_rst");
        step(C_IC, F, Q_0);
        step(C_0, D, Q_DEC);

        @(negedge clk);
        #2;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
